// File: rtl/dcp_pkg.sv
// rtl/dcp_pkg.sv - shared constants and reciprocal table builder for the DCP recovery stage
// recip table entry i holds floor(DEVIDER / max(i, T_MIN)), i.e. 255/t in Q4.
package dcp_pkg;

  localparam int DEVIDER = 4080;
  localparam int T_MIN   = 26;
  localparam int FRAC_W  = 4;
  localparam int RECIP_W = 12;
  localparam int PIX_W   = 8;
  localparam int LATENCY = 3;
  localparam int NUM_CH  = 3;
  localparam int PROD_W  = 22;

  typedef logic [255:0][RECIP_W-1:0] recip_lut_t;

  function automatic recip_lut_t build_recip_lut();
    recip_lut_t lut;
    for (int i = 0; i < 256; i++) begin
      int t_eff;
      t_eff  = (i < T_MIN) ? T_MIN : i;
      lut[i] = RECIP_W'(DEVIDER / t_eff);
    end
    return lut;
  endfunction

endpackage

// File: rtl/dcp_channel_recover.sv
// rtl/dcp_channel_recover.sv - stages 2-3 for one colour channel
// prod = diff * recip, then round-half-up, add A back and saturate to a pixel.
module dcp_channel_recover
  import dcp_pkg::*;
(
  input  logic                     pixelclk,
  input  logic                     reset_n,
  input  logic signed [PIX_W:0]    i_diff,
  input  logic [RECIP_W-1:0]       i_recip,
  input  logic [PIX_W-1:0]         i_a,
  output logic [PIX_W-1:0]         o_pix
);

  localparam logic signed [PROD_W-1:0] ROUND_C = PROD_W'(1 << (FRAC_W - 1));

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic [PIX_W-1:0]         a_d, a_q;
  logic [PIX_W-1:0]         out_d, out_q;

  logic signed [PROD_W-1:0] diff_ext, recip_ext, a_ext, rnd, q, s;

  always_comb begin
    diff_ext  = {{(PROD_W - PIX_W - 1){i_diff[PIX_W]}}, i_diff};
    recip_ext = {{(PROD_W - RECIP_W){1'b0}}, i_recip};
    prod_d    = diff_ext * recip_ext;
    a_d       = i_a;
  end

  always_comb begin
    a_ext = $signed({{(PROD_W - PIX_W){1'b0}}, a_q});
    rnd   = prod_q + ROUND_C;
    q     = rnd >>> FRAC_W;
    s     = q + a_ext;
    out_d = s[PIX_W-1:0];
    if (s[PROD_W-1]) begin
      out_d = '0;
    end else if (|s[PROD_W-2:PIX_W]) begin
      out_d = '1;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      prod_q <= '0;
      a_q    <= '0;
      out_q  <= '0;
    end else begin
      prod_q <= prod_d;
      a_q    <= a_d;
      out_q  <= out_d;
    end
  end

  assign o_pix = out_q;

endmodule

// File: rtl/dcp_defogging.sv
// rtl/dcp_defogging.sv - DCP recovery J = A + (I - A)/t, fixed 3-cycle pipeline
// Stage 1 (LUT, diffs) lives here; stages 2-3 are per-channel instances.
module dcp_defogging
  import dcp_pkg::*;
(
  input  logic                        pixelclk,
  input  logic                        reset_n,
  input  logic [NUM_CH*PIX_W-1:0]     i_rgb,
  input  logic [PIX_W-1:0]            i_transmittance,
  input  logic [PIX_W-1:0]            i_dark_max,
  input  logic                        i_data_valid,
  output logic [NUM_CH*PIX_W-1:0]     o_defogging,
  output logic                        o_data_valid
);

  localparam recip_lut_t RECIP_LUT = build_recip_lut();

  logic [RECIP_W-1:0]     recip_d, recip_q;
  logic [PIX_W-1:0]       a_d, a_q;
  logic signed [PIX_W:0]  diff_d [NUM_CH];
  logic signed [PIX_W:0]  diff_q [NUM_CH];
  logic [LATENCY-1:0]     valid_d, valid_q;

  // Low table entries already hold the T_MIN reciprocal, so raw t indexes directly.
  always_comb begin
    recip_d = RECIP_LUT[i_transmittance];
    a_d     = i_dark_max;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      diff_d[ch] = $signed({1'b0, i_rgb[ch*PIX_W +: PIX_W]}) - $signed({1'b0, i_dark_max});
    end
    valid_d = {valid_q[LATENCY-2:0], i_data_valid};
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      recip_q <= '0;
      a_q     <= '0;
      valid_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        diff_q[ch] <= '0;
      end
    end else begin
      recip_q <= recip_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        diff_q[ch] <= diff_d[ch];
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    dcp_channel_recover u_recover (
      .pixelclk (pixelclk),
      .reset_n  (reset_n),
      .i_diff   (diff_q[ch]),
      .i_recip  (recip_q),
      .i_a      (a_q),
      .o_pix    (o_defogging[ch*PIX_W +: PIX_W])
    );
  end

  assign o_data_valid = valid_q[LATENCY-1];

endmodule

// File: tb/tb_dcp_defogging.sv
// tb/tb_dcp_defogging.sv - randomized self-checking bench for dcp_defogging
// Reference model evaluates J = A + (I - A)*255/t with integer arithmetic per pixel.
module tb_dcp_defogging;

  logic        pixelclk = 1'b0;
  logic        reset_n;
  logic [23:0] i_rgb;
  logic [7:0]  i_transmittance;
  logic [7:0]  i_dark_max;
  logic        i_data_valid;
  logic [23:0] o_defogging;
  logic        o_data_valid;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  typedef struct {
    logic        v;
    logic [23:0] pix;
    logic        chk_pix;
  } exp_t;

  exp_t exp_q[$];

  dcp_defogging dut (
    .pixelclk        (pixelclk),
    .reset_n         (reset_n),
    .i_rgb           (i_rgb),
    .i_transmittance (i_transmittance),
    .i_dark_max      (i_dark_max),
    .i_data_valid    (i_data_valid),
    .o_defogging     (o_defogging),
    .o_data_valid    (o_data_valid)
  );

  always #5 pixelclk = ~pixelclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div16(input int num);
    if (num >= 0) return num / 16;
    return -((-num + 15) / 16);
  endfunction

  function automatic logic [23:0] model(input logic [23:0] rgb, input int t, input int a);
    logic [23:0] res;
    int teff, recip, diff, q, s;
    logic [7:0] chan;
    teff  = (t < 26) ? 26 : t;
    recip = 4080 / teff;
    res   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      chan = rgb[ch*8 +: 8];
      diff = int'(chan) - a;
      q    = floor_div16(diff * recip + 8);
      s    = q + a;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      res[ch*8 +: 8] = 8'(s);
    end
    return res;
  endfunction

  task automatic cycle(input logic rst_n, input logic [23:0] rgb, input logic [7:0] t,
                       input logic [7:0] a, input logic v);
    exp_t e;
    reset_n         = rst_n;
    i_rgb           = rgb;
    i_transmittance = t;
    i_dark_max      = a;
    i_data_valid    = v;
    @(posedge pixelclk);
    #1;
    if (!rst_n) begin
      armed = 1'b1;
      exp_q.delete();
      repeat (3) exp_q.push_back('{v: 1'b0, pix: 24'h0, chk_pix: 1'b1});
    end else begin
      exp_q.push_back('{v: v, pix: model(rgb, int'(t), int'(a)), chk_pix: v});
      if (exp_q.size() > 3) void'(exp_q.pop_front());
    end
    if (armed) begin
      e = exp_q[0];
      chk("valid", 32'(o_data_valid), 32'(e.v));
      if (e.chk_pix) chk("pixel", 32'(o_defogging), 32'(e.pix));
    end
  endtask

  task automatic rnd_cycle(input logic rst_n, input logic v);
    cycle(rst_n, 24'($urandom), 8'($urandom), 8'($urandom), v);
  endtask

  task automatic directed(input string tag, input logic [23:0] rgb, input logic [7:0] t,
                          input logic [7:0] a, input logic [23:0] exp);
    cycle(1'b1, rgb, t, a, 1'b1);
    rnd_cycle(1'b1, 1'b0);
    rnd_cycle(1'b1, 1'b0);
    chk(tag, 32'(o_defogging), 32'(exp));
    chk({tag, "_v"}, 32'(o_data_valid), 32'd1);
  endtask

  initial begin
    logic [4:0] pat;
    repeat (10) begin
      rnd_cycle(1'b0, 1'($urandom));
      chk("rst_pix", 32'(o_defogging), 32'd0);
      chk("rst_v", 32'(o_data_valid), 32'd0);
    end

    // Reciprocal of 16 at t=242 makes the stage an identity map.
    directed("id_0", 24'h000000, 8'd242, 8'd255, 24'h000000);
    directed("id_ff80ff", 24'hFF80FF, 8'd242, 8'd255, 24'hFF80FF);
    repeat (50) cycle(1'b1, 24'($urandom), 8'd242, 8'd255, 1'b1);

    directed("t128", 24'h64C8FF, 8'd128, 8'd200, 24'h06C8FF);
    directed("t26", 24'hC86400, 8'd26, 8'd100, 24'hFF6400);
    directed("t10", 24'hC86400, 8'd10, 8'd100, 24'hFF6400);
    directed("t0", 24'hC86400, 8'd0, 8'd100, 24'hFF6400);
    directed("i_eq_a", 24'h373737, 8'd77, 8'h37, 24'h373737);

    pat = 5'b01101;
    for (int i = 0; i < 5; i++) rnd_cycle(1'b1, pat[i]);
    rnd_cycle(1'b1, 1'b1);
    rnd_cycle(1'b1, 1'b1);
    rnd_cycle(1'b0, 1'b1);
    chk("mid_rst_pix", 32'(o_defogging), 32'd0);
    chk("mid_rst_v", 32'(o_data_valid), 32'd0);
    repeat (4) rnd_cycle(1'b1, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      rnd_cycle(($urandom_range(0, 999) != 0), ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
